// File: rtl/instruction_loader_pkg.sv
// Shared definitions for instruction_loader: state encoding, default sizes,
// and the instruction-memory constants (HALT word, clear value).
package instruction_loader_pkg;

  localparam int unsigned DEFAULT_LOADER_REG_SIZE         = 32;
  localparam int unsigned DEFAULT_LOADER_BYTE_SIZE        = 8;
  localparam int unsigned DEFAULT_LOADER_MAX_INSTRUCTIONS = 64;

  localparam int unsigned BITS_FOR_STATE_LOADER = 3;

  // Instruction memory constants shared with the IF stage.
  localparam logic [31:0] INSTRUCTION_HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] CLEAR            = 32'h0000_0000;

  typedef enum logic [BITS_FOR_STATE_LOADER-1:0] {
    STATE_LOADER_COLLECT      = 3'd0,
    STATE_LOADER_WRITE_STROBE = 3'd1,
    STATE_LOADER_WRITE_HOLD   = 3'd2,
    STATE_LOADER_DONE         = 3'd3,
    STATE_LOADER_RUN          = 3'd4,
    STATE_LOADER_ERROR        = 3'd5
  } loader_state_e;

endpackage

// File: rtl/instruction_loader.sv
// instruction_loader: assembles UART bytes (MSB first) into instruction words,
// writes each with a strobe+hold handshake, counts words, detects HALT and
// gates the pipeline start pulse.
// Ports:
//   i_clk, i_reset (async, active-high)
//   i_rx_valid / i_rx_byte   : received UART byte
//   i_start_request          : debug-unit start request
//   o_instruction_write      : one-cycle write strobe
//   o_instruction            : assembled word (stable through strobe + hold)
//   o_instruction_count      : words written, HALT included
//   o_load_done / o_start    : HALT written / start pulse
//   o_error                  : sticky overflow flag
// Optional: LOADER_INTERBYTE_TIMEOUT_EN adds TIMEOUT_CYCLES partial-word timeout.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int unsigned REG_SIZE         = DEFAULT_LOADER_REG_SIZE,
  parameter int unsigned BYTE_SIZE        = DEFAULT_LOADER_BYTE_SIZE,
  parameter int unsigned MAX_INSTRUCTIONS = DEFAULT_LOADER_MAX_INSTRUCTIONS
`ifdef LOADER_INTERBYTE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1_000_000
`endif
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_rx_valid,
  input  logic [BYTE_SIZE-1:0]                i_rx_byte,
  input  logic                                i_start_request,
  output logic                                o_instruction_write,
  output logic [REG_SIZE-1:0]                 o_instruction,
  output logic [$clog2(MAX_INSTRUCTIONS):0]   o_instruction_count,
  output logic                                o_load_done,
  output logic                                o_start,
  output logic                                o_error
);

  localparam int unsigned BYTES_PER_WORD = REG_SIZE / BYTE_SIZE;
  localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);
  localparam int unsigned CNT_W          = $clog2(MAX_INSTRUCTIONS) + 1;
  localparam logic [BCNT_W-1:0]   BYTE_LAST = BCNT_W'(BYTES_PER_WORD - 1);
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(MAX_INSTRUCTIONS - 1);
  localparam logic [REG_SIZE-1:0] HALT_WORD = REG_SIZE'(INSTRUCTION_HALT);
  localparam logic [REG_SIZE-1:0] CLEAR_WORD = REG_SIZE'(CLEAR);

  loader_state_e        state_q, state_d;
  logic [BCNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [REG_SIZE-1:0]  word_q, word_d;
  logic [REG_SIZE-1:0]  instr_q, instr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [BYTE_SIZE-1:0] skid_byte_q, skid_byte_d;
  logic                 write_q, write_d;
  logic                 start_q, start_d;
  logic                 load_done_q, load_done_d;
  logic                 error_q, error_d;

  logic                 in_valid;
  logic [BYTE_SIZE-1:0] in_byte;
  logic [REG_SIZE-1:0]  shifted;

`ifdef LOADER_INTERBYTE_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMR_W-1:0] timer_q, timer_d;
`endif

  // State and datapath registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= STATE_LOADER_COLLECT;
      byte_cnt_q   <= '0;
      word_q       <= CLEAR_WORD;
      instr_q      <= CLEAR_WORD;
      count_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_byte_q  <= '0;
      write_q      <= 1'b0;
      start_q      <= 1'b0;
      load_done_q  <= 1'b0;
      error_q      <= 1'b0;
`ifdef LOADER_INTERBYTE_TIMEOUT_EN
      timer_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      instr_q      <= instr_d;
      count_q      <= count_d;
      skid_valid_q <= skid_valid_d;
      skid_byte_q  <= skid_byte_d;
      write_q      <= write_d;
      start_q      <= start_d;
      load_done_q  <= load_done_d;
      error_q      <= error_d;
`ifdef LOADER_INTERBYTE_TIMEOUT_EN
      timer_q      <= timer_d;
`endif
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    instr_d      = instr_q;
    count_d      = count_q;
    skid_valid_d = skid_valid_q;
    skid_byte_d  = skid_byte_q;
    write_d      = 1'b0;
    start_d      = 1'b0;
    load_done_d  = load_done_q;
    error_d      = error_q;
    in_valid     = 1'b0;
    in_byte      = '0;
    shifted      = '0;
`ifdef LOADER_INTERBYTE_TIMEOUT_EN
    timer_d      = timer_q;
`endif

    unique case (state_q)
      STATE_LOADER_COLLECT: begin
        // A buffered byte is older, so it goes first; a new byte refills the buffer.
        if (skid_valid_q) begin
          in_valid     = 1'b1;
          in_byte      = skid_byte_q;
          skid_valid_d = i_rx_valid;
          skid_byte_d  = i_rx_byte;
        end else if (i_rx_valid) begin
          in_valid = 1'b1;
          in_byte  = i_rx_byte;
        end
        shifted = {word_q[REG_SIZE-BYTE_SIZE-1:0], in_byte};

        if (in_valid) begin
`ifdef LOADER_INTERBYTE_TIMEOUT_EN
          timer_d = '0;
`endif
          if (byte_cnt_q == BYTE_LAST) begin
            byte_cnt_d = '0;
            word_d     = CLEAR_WORD;
            // The last memory slot is reserved for HALT.
            if (count_q == CNT_LAST && shifted != HALT_WORD) begin
              state_d = STATE_LOADER_ERROR;
              error_d = 1'b1;
            end else begin
              instr_d = shifted;
              write_d = 1'b1;
              state_d = STATE_LOADER_WRITE_STROBE;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
            word_d     = shifted;
          end
        end
`ifdef LOADER_INTERBYTE_TIMEOUT_EN
        else if (byte_cnt_q != '0) begin
          // Stalled partial word: drop it and resynchronise on the next byte.
          if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            timer_d    = '0;
            byte_cnt_d = '0;
            word_d     = CLEAR_WORD;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
`endif
      end

      STATE_LOADER_WRITE_STROBE, STATE_LOADER_WRITE_HOLD: begin
        if (state_q == STATE_LOADER_WRITE_HOLD) begin
          count_d = count_q + CNT_W'(1);
        end
        if (i_rx_valid && skid_valid_q) begin
          state_d = STATE_LOADER_ERROR;
          error_d = 1'b1;
        end else begin
          if (i_rx_valid) begin
            skid_valid_d = 1'b1;
            skid_byte_d  = i_rx_byte;
          end
          if (state_q == STATE_LOADER_WRITE_STROBE) begin
            state_d = STATE_LOADER_WRITE_HOLD;
          end else if (instr_q == HALT_WORD) begin
            state_d      = STATE_LOADER_DONE;
            load_done_d  = 1'b1;
            skid_valid_d = 1'b0;
          end else begin
            state_d = STATE_LOADER_COLLECT;
          end
        end
      end

      STATE_LOADER_DONE: begin
        if (i_start_request) begin
          start_d = 1'b1;
          state_d = STATE_LOADER_RUN;
        end
      end

      STATE_LOADER_RUN, STATE_LOADER_ERROR: begin
        state_d = state_q;
      end

      default: begin
        state_d = STATE_LOADER_ERROR;
        error_d = 1'b1;
      end
    endcase
  end

  assign o_instruction_write = write_q;
  assign o_instruction       = instr_q;
  assign o_instruction_count = count_q;
  assign o_load_done         = load_done_q;
  assign o_start             = start_q;
  assign o_error             = error_q;

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
Upstream feeder of the instruction memory in the IF stage. It assembles bytes from the UART receiver into REG_SIZE-bit instruction words. Each word is delivered with the two-cycle write handshake the instruction memory expects. The block tracks the instruction count, detects the HALT word, and then gates the pipeline start command.

Parameters:
- REG_SIZE, 32, instruction width in bits; must be a multiple of BYTE_SIZE.
- BYTE_SIZE, 8, UART payload width.
- MAX_INSTRUCTIONS, 64, instruction memory capacity in words, HALT included (MEM_SIZE / REG_SIZE).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_valid  in  1  one-cycle pulse: i_rx_byte is valid.
- i_rx_byte  in  BYTE_SIZE  received byte.
- i_start_request  in  1  debug-unit request to begin execution.
- o_instruction_write  out  1  one-cycle write strobe to the instruction memory.
- o_instruction  out  REG_SIZE  assembled word; held stable through the strobe cycle and the following cycle.
- o_instruction_count  out  clog2(MAX_INSTRUCTIONS)+1  number of words written, HALT included.
- o_load_done  out  1  high once HALT has been written.
- o_start  out  1  one-cycle pulse to the memory/PC start input.
- o_error  out  1  sticky capacity-overflow flag.

Behaviour:
Reset values:
- All outputs 0; state COLLECT; byte counter 0; skid buffer empty.
- Reset is asynchronous and takes effect mid-word or mid-handshake; the partial word is discarded.

Word assembly:
- Bytes arrive MSB first.
- Assembly register: word <= {word[REG_SIZE-BYTE_SIZE-1:0], byte}.
- Byte counter runs 0..REG_SIZE/BYTE_SIZE-1.

State COLLECT:
- On a valid byte (from i_rx_valid or the skid buffer), shift it in.
- When the last byte of a word arrives:
  - If count == MAX_INSTRUCTIONS-1 and the word is not INSTRUCTION_HALT -> ERROR; no write.
  - Otherwise latch o_instruction -> WRITE_STROBE.

State WRITE_STROBE (1 cycle):
- o_instruction_write=1 -> WRITE_HOLD.

State WRITE_HOLD (1 cycle):
- o_instruction held; the memory samples the word in this cycle.
- count increments.
- If the word is HALT -> DONE; otherwise -> COLLECT.

Skid buffer:
- One-entry buffer for bytes that arrive in WRITE_STROBE or WRITE_HOLD.
- It is consumed in the first COLLECT cycle, with priority over a simultaneous new i_rx_valid.
- That simultaneous byte is accepted into the buffer.
- A byte arriving while the buffer is full sets o_error and the block goes to ERROR.

State DONE:
- o_load_done=1; incoming bytes ignored.
- i_start_request -> o_start pulses for 1 cycle in the next cycle -> RUN.
- i_start_request before DONE is ignored, with no latching.

State RUN:
- o_load_done stays 1; all inputs ignored until reset.

State ERROR:
- o_error=1; no writes, no start; exit only by reset.

Latency:
- Last byte in -> strobe: 1 cycle.
- Strobe -> return to COLLECT: 2 cycles.
- i_start_request -> o_start: 1 cycle.

Optional Feature:
Macro LOADER_INTERBYTE_TIMEOUT_EN.
- Defined:
  - Parameter TIMEOUT_CYCLES, default 1_000_000.
  - A counter runs in COLLECT while the byte counter is non-zero; it clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES-1, the partial word is discarded and the byte counter is cleared.
  - count and state are unaffected; o_error is not set.
- Not defined: a partial word waits indefinitely.

Decomposition:
Shared header instruction_loader.vh holds:
- state encodings STATE_LOADER_COLLECT / WRITE_STROBE / WRITE_HOLD / DONE / RUN / ERROR and BITS_FOR_STATE_LOADER;
- defaults DEFAULT_LOADER_REG_SIZE / BYTE_SIZE / MAX_INSTRUCTIONS.

The block reuses INSTRUCTION_HALT and CLEAR from the existing instruction memory header. No sub-module is needed; the shift/counter logic stays inline.

Test Plan:
1. Bytes 8'h20,8'h01,8'h00,8'h05 -> o_instruction=32'h20010005; strobe 1 cycle after the last byte, word held 2 cycles; count=1.
2. Two words, then HALT bytes -> strobes on the 2 words and on HALT; count=3, o_load_done=1; a later i_start_request gives a single o_start pulse.
3. A byte arriving during WRITE_STROBE, followed by 3 more -> the buffered byte becomes the MSB of the next word; no loss; o_error=0.
4. MAX_INSTRUCTIONS-1 non-HALT words, then a non-HALT word -> no 64th strobe; o_error=1; i_start_request ignored.
5. Reset asserted after 2 of 4 bytes, then 4 fresh bytes -> the word equals the fresh bytes only; all outputs 0 during reset.
6. (LOADER_INTERBYTE_TIMEOUT_EN, TIMEOUT_CYCLES=16) 2 bytes, 20 idle cycles, 4 bytes -> one strobe with the 4-byte word; o_error=0.
